alu_seq_ctrl: RTL and testbench

- Byte-stream sequencer for the 8-bit ALU datapath. It replaces the three enable buttons with a framed protocol.
- It accepts three bytes in order (operand A, operand B, opcode byte), holds them stable on the ALU inputs, and waits a settle cycle. It then captures result and flags and emits two response bytes (result, flags) on a valid/ready output stream.
- It sits between a UART rx/tx pair and the ALU instance.

---
 rtl/alu_seq_ctrl.sv | 138 +++++++++++++
 tb/tb_alu_seq_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_ctrl.sv
// Byte-stream sequencer for the 8-bit ALU: collects A, B, opcode, then returns result and flags.
// Optional inter-byte timeout is enabled with `define ALU_SEQ_TIMEOUT_EN.
module alu_seq_ctrl #(
   parameter int NB_DATA     = 8,
   parameter int NB_OP       = 6,
   parameter int NB_CNT      = 8,
   parameter int TIMEOUT_CYC = 1000000
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic [NB_DATA-1:0] i_rx_data,
   input  logic               i_rx_valid,
   output logic               o_rx_ready,
   output logic [NB_DATA-1:0] o_data_a,
   output logic [NB_DATA-1:0] o_data_b,
   output logic [NB_OP-1:0]   o_op,
   input  logic [NB_DATA-1:0] i_alu_result,
   input  logic               i_alu_carry,
   input  logic               i_alu_zero,
   output logic [NB_DATA-1:0] o_tx_data,
   output logic               o_tx_valid,
   input  logic               i_tx_ready,
   output logic               o_busy,
   output logic [NB_CNT-1:0]  o_op_count,
   output logic               o_error
);

   typedef enum logic [2:0] {
      GET_A,
      GET_B,
      GET_OP,
      EXEC,
      SEND_RES,
      SEND_FLG
   } state_t;

   state_t state, next_state;
   logic   rx_xfer;
   logic   tx_xfer;
   logic   timeout;
   logic   carry_q;
   logic   zero_q;

   assign o_rx_ready = (state == GET_A) || (state == GET_B) || (state == GET_OP);
   assign rx_xfer    = i_rx_valid & o_rx_ready;
   assign tx_xfer    = o_tx_valid & i_tx_ready;
   assign o_busy     = (state != GET_A);

`ifdef ALU_SEQ_TIMEOUT_EN
   localparam int NB_TMO = ($clog2(TIMEOUT_CYC) > 0) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [NB_TMO-1:0] TMO_LAST = NB_TMO'(TIMEOUT_CYC - 1);

   logic [NB_TMO-1:0] tmo_cnt;
   logic              waiting;
   logic              error_q;

   assign waiting = (state == GET_B) || (state == GET_OP);
   assign timeout = waiting && !rx_xfer && (tmo_cnt == TMO_LAST);
   assign o_error = error_q;

   // The counter only runs mid-frame; it is held at zero in GET_A so a new frame starts fresh.
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         tmo_cnt <= '0;
         error_q <= 1'b0;
      end else begin
         error_q <= timeout;
         if (!waiting || rx_xfer || timeout)
            tmo_cnt <= '0;
         else
            tmo_cnt <= tmo_cnt + 1'b1;
      end
   end
`else
   assign timeout = 1'b0;
   assign o_error = 1'b0;
`endif

   always_ff @(posedge i_clk) begin
      if (!i_reset)
         state <= GET_A;
      else
         state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         GET_A:    if (rx_xfer) next_state = GET_B;
         GET_B:    if (rx_xfer) next_state = GET_OP;
                   else if (timeout) next_state = GET_A;
         GET_OP:   if (rx_xfer) next_state = EXEC;
                   else if (timeout) next_state = GET_A;
         EXEC:     next_state = SEND_RES;
         SEND_RES: if (tx_xfer) next_state = SEND_FLG;
         SEND_FLG: if (tx_xfer) next_state = GET_A;
         default:  next_state = GET_A;
      endcase
   end

   // Operand registers stay loaded after a frame so the ALU output remains valid until the next A.
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         o_data_a   <= '0;
         o_data_b   <= '0;
         o_op       <= '0;
         o_tx_data  <= '0;
         o_tx_valid <= 1'b0;
         o_op_count <= '0;
         carry_q    <= 1'b0;
         zero_q     <= 1'b0;
      end else begin
         case (state)
            GET_A:    if (rx_xfer) o_data_a <= i_rx_data;
            GET_B:    if (rx_xfer) o_data_b <= i_rx_data;
            GET_OP:   if (rx_xfer) o_op <= i_rx_data[NB_DATA-1:NB_DATA-NB_OP];
            EXEC: begin
               carry_q    <= i_alu_carry;
               zero_q     <= i_alu_zero;
               o_tx_data  <= i_alu_result;
               o_tx_valid <= 1'b1;
            end
            SEND_RES: begin
               if (tx_xfer)
                  o_tx_data <= {{(NB_DATA-2){1'b0}}, carry_q, zero_q};
            end
            SEND_FLG: begin
               if (tx_xfer) begin
                  o_tx_valid <= 1'b0;
                  o_op_count <= o_op_count + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl with an adder stub standing in for the ALU.
// Timeout checks run only when ALU_SEQ_TIMEOUT_EN is defined (TIMEOUT_CYC is set to 16 here).
module tb_alu_seq_ctrl;

   logic       i_clk = 1'b0;
   logic       i_reset;
   logic [7:0] i_rx_data;
   logic       i_rx_valid;
   logic       o_rx_ready;
   logic [7:0] o_data_a;
   logic [7:0] o_data_b;
   logic [5:0] o_op;
   logic [7:0] i_alu_result;
   logic       i_alu_carry;
   logic       i_alu_zero;
   logic [7:0] o_tx_data;
   logic       o_tx_valid;
   logic       i_tx_ready;
   logic       o_busy;
   logic [7:0] o_op_count;
   logic       o_error;

   logic [8:0] alu_sum;

   int checks = 0;
   int passes = 0;
   int fails  = 0;
   logic [7:0] exp_count = 8'h00;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] op_byte;
      logic [5:0] exp_op;
      logic [7:0] exp_res;
      logic [7:0] exp_flg;
   } vec_t;

   vec_t vecs[6];

   alu_seq_ctrl #(
      .NB_DATA(8), .NB_OP(6), .NB_CNT(8), .TIMEOUT_CYC(16)
   ) dut (
      .i_clk(i_clk), .i_reset(i_reset),
      .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid), .o_rx_ready(o_rx_ready),
      .o_data_a(o_data_a), .o_data_b(o_data_b), .o_op(o_op),
      .i_alu_result(i_alu_result), .i_alu_carry(i_alu_carry), .i_alu_zero(i_alu_zero),
      .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready),
      .o_busy(o_busy), .o_op_count(o_op_count), .o_error(o_error)
   );

   always #5 i_clk = ~i_clk;

   assign alu_sum      = {1'b0, o_data_a} + {1'b0, o_data_b};
   assign i_alu_result = alu_sum[7:0];
   assign i_alu_carry  = alu_sum[8];
   assign i_alu_zero   = (alu_sum[7:0] == 8'h00);

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual === expected) begin
         passes++;
      end else begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Hold the byte until the controller is ready; the transfer happens on the next rising edge.
   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      i_rx_data  = b;
      i_rx_valid = 1'b1;
      while (!o_rx_ready && n < 50) begin
         @(negedge i_clk);
         n++;
      end
      if (n >= 50) checkOutput("rx_ready_wait", {31'd0, o_rx_ready}, 32'd1);
      @(negedge i_clk);
      i_rx_valid = 1'b0;
   endtask

   task automatic recv_byte(input string name, input logic [7:0] expected);
      int n = 0;
      while (!o_tx_valid && n < 50) begin
         @(negedge i_clk);
         n++;
      end
      if (n >= 50) checkOutput({name, "_valid_wait"}, {31'd0, o_tx_valid}, 32'd1);
      checkOutput(name, {24'd0, o_tx_data}, {24'd0, expected});
      i_tx_ready = 1'b1;
      @(negedge i_clk);
      i_tx_ready = 1'b0;
   endtask

   task automatic applyStimulus(input vec_t v);
      send_byte(v.a);
      send_byte(v.b);
      send_byte(v.op_byte);
      checkOutput("data_a", {24'd0, o_data_a}, {24'd0, v.a});
      checkOutput("data_b", {24'd0, o_data_b}, {24'd0, v.b});
      checkOutput("op", {26'd0, o_op}, {26'd0, v.exp_op});
      checkOutput("tx_valid_in_exec", {31'd0, o_tx_valid}, 32'd0);
      @(negedge i_clk);
      checkOutput("tx_valid_latency", {31'd0, o_tx_valid}, 32'd1);
      recv_byte("result", v.exp_res);
      recv_byte("flags", v.exp_flg);
      exp_count = exp_count + 8'd1;
      checkOutput("op_count", {24'd0, o_op_count}, {24'd0, exp_count});
      checkOutput("busy_after_frame", {31'd0, o_busy}, 32'd0);
      checkOutput("tx_valid_after_frame", {31'd0, o_tx_valid}, 32'd0);
   endtask

   function automatic logic [7:0] stream_byte(input int k);
      int f = k / 3;
      case (k % 3)
         0:       stream_byte = 8'(f * 7 + 1);
         1:       stream_byte = 8'(f * 3);
         default: stream_byte = 8'h80;
      endcase
   endfunction

   function automatic logic [7:0] model_tx(input int t);
      int         f = t / 2;
      logic [8:0] s;
      s = {1'b0, 8'(f * 7 + 1)} + {1'b0, 8'(f * 3)};
      if (t % 2 == 0) model_tx = s[7:0];
      else            model_tx = {6'd0, s[8], (s[7:0] == 8'h00)};
   endfunction

   initial begin
      int consumed;
      int txcnt;
      int cyc;
      logic will_take;

      vecs[0] = '{8'h05, 8'h03, 8'h80, 6'h20, 8'h08, 8'h00};
      vecs[1] = '{8'hFF, 8'h01, 8'h80, 6'h20, 8'h00, 8'h03};
      vecs[2] = '{8'hF0, 8'h20, 8'hFF, 6'h3F, 8'h10, 8'h02};
      vecs[3] = '{8'h00, 8'h00, 8'h07, 6'h01, 8'h00, 8'h01};
      vecs[4] = '{8'h7F, 8'h01, 8'hA4, 6'h29, 8'h80, 8'h00};
      vecs[5] = '{8'hAA, 8'h55, 8'hFC, 6'h3F, 8'hFF, 8'h00};

      i_reset    = 1'b0;
      i_rx_data  = 8'h00;
      i_rx_valid = 1'b0;
      i_tx_ready = 1'b0;
      repeat (3) @(negedge i_clk);
      checkOutput("rst_busy", {31'd0, o_busy}, 32'd0);
      checkOutput("rst_rx_ready", {31'd0, o_rx_ready}, 32'd1);
      checkOutput("rst_tx_valid", {31'd0, o_tx_valid}, 32'd0);
      checkOutput("rst_op_count", {24'd0, o_op_count}, 32'd0);
      checkOutput("rst_error", {31'd0, o_error}, 32'd0);
      checkOutput("rst_data_a", {24'd0, o_data_a}, 32'd0);
      i_reset = 1'b1;
      @(negedge i_clk);

      // Reset in the middle of a frame must throw away the partial frame.
      send_byte(8'h12);
      checkOutput("mid_data_a", {24'd0, o_data_a}, 32'h12);
      checkOutput("mid_busy", {31'd0, o_busy}, 32'd1);
      i_reset = 1'b0;
      repeat (2) @(negedge i_clk);
      i_reset = 1'b1;
      checkOutput("mid_rst_busy", {31'd0, o_busy}, 32'd0);
      checkOutput("mid_rst_rx_ready", {31'd0, o_rx_ready}, 32'd1);
      checkOutput("mid_rst_tx_valid", {31'd0, o_tx_valid}, 32'd0);
      checkOutput("mid_rst_op_count", {24'd0, o_op_count}, 32'd0);
      checkOutput("mid_rst_data_a", {24'd0, o_data_a}, 32'd0);

      for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

      // Backpressure: result must hold while rx is offered and ignored.
      send_byte(8'h05);
      send_byte(8'h03);
      send_byte(8'h80);
      @(negedge i_clk);
      i_rx_data  = 8'h77;
      i_rx_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         checkOutput("bp_tx_data", {24'd0, o_tx_data}, 32'h08);
         checkOutput("bp_tx_valid", {31'd0, o_tx_valid}, 32'd1);
         checkOutput("bp_rx_ready", {31'd0, o_rx_ready}, 32'd0);
         @(negedge i_clk);
      end
      i_rx_valid = 1'b0;
      checkOutput("bp_data_a_held", {24'd0, o_data_a}, 32'h05);
      recv_byte("bp_result", 8'h08);
      recv_byte("bp_flags", 8'h00);
      exp_count = exp_count + 8'd1;
      checkOutput("bp_op_count", {24'd0, o_op_count}, {24'd0, exp_count});

      // 256 streamed frames with rx valid and tx ready held high the whole time.
      consumed   = 0;
      txcnt      = 0;
      cyc        = 0;
      i_tx_ready = 1'b1;
      while (txcnt < 512 && cyc < 5000) begin
         if (consumed < 768) begin
            i_rx_valid = 1'b1;
            i_rx_data  = stream_byte(consumed);
         end else begin
            i_rx_valid = 1'b0;
         end
         if (o_tx_valid) begin
            checkOutput("stream_tx", {24'd0, o_tx_data}, {24'd0, model_tx(txcnt)});
            txcnt++;
         end
         will_take = o_rx_ready && i_rx_valid;
         @(negedge i_clk);
         cyc++;
         if (will_take) consumed++;
      end
      i_rx_valid = 1'b0;
      i_tx_ready = 1'b0;
      checkOutput("stream_tx_count", txcnt, 32'd512);
      checkOutput("stream_rx_count", consumed, 32'd768);
      checkOutput("wrap_op_count", {24'd0, o_op_count}, {24'd0, exp_count});
      checkOutput("stream_busy", {31'd0, o_busy}, 32'd0);
      checkOutput("stream_last_a", {24'd0, o_data_a}, {24'd0, stream_byte(765)});

`ifdef ALU_SEQ_TIMEOUT_EN
      begin
         int pulses = 0;
         int first_at = -1;
         send_byte(8'h22);
         for (int i = 1; i <= 20; i++) begin
            @(negedge i_clk);
            if (o_error) begin
               pulses++;
               if (first_at < 0) first_at = i;
            end
         end
         checkOutput("tmo_pulses", pulses, 32'd1);
         checkOutput("tmo_cycle", first_at, 32'd16);
         checkOutput("tmo_busy", {31'd0, o_busy}, 32'd0);
         checkOutput("tmo_data_a", {24'd0, o_data_a}, 32'h22);
         checkOutput("tmo_op_count", {24'd0, o_op_count}, {24'd0, exp_count});
         applyStimulus('{8'h01, 8'h01, 8'h80, 6'h20, 8'h02, 8'h00});
      end
`endif

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
